// File: rtl/FPALL_pkg.sv
// Shared format and opcode encodings for the FPALL arithmetic unit and its wrappers.
package FPALL_pkg;

  typedef enum logic [1:0] {
    FP16,
    FP32
  } fp_fmt_e;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_MIN,
    OP_MAX
  } fp_op_e;

endpackage

// File: rtl/fpall_issue_ctrl.sv
// Issue/collect stage around the shared FP unit: registers operands, tracks in-flight ops for
// CORE_LAT cycles and queues results in a credit-protected FIFO. Optional: FPALL_ISSUE_PERF_EN.
module fpall_issue_ctrl
  import FPALL_pkg::*;
#(
  parameter int unsigned CORE_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          in_fmt,
  input  fp_op_e           in_opcode,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output fp_fmt_e          core_fmt,
  output fp_op_e           core_opcode,
  output logic [31:0]      core_x,
  output logic [31:0]      core_y,
  input  logic [31:0]      core_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag
`ifdef FPALL_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_bp
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = $clog2(FIFO_DEPTH + CORE_LAT + 1);

  logic [CORE_LAT-1:0] vld_q;
  logic [TAG_W-1:0]    tag_q [CORE_LAT];
  logic [31:0]         mem_r_q [FIFO_DEPTH];
  logic [TAG_W-1:0]    mem_tag_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic [SumW-1:0]     inflight;
  logic                accept, push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < CORE_LAT; i++) begin
      inflight = inflight + SumW'(vld_q[i]);
    end
  end

  // Every accepted op owns a FIFO slot from issue until it is popped.
  assign in_ready  = (inflight + SumW'(count_q)) < SumW'(FIFO_DEPTH);
  assign accept    = in_valid & in_ready;
  assign push      = vld_q[CORE_LAT-1];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign count_d   = count_q + CntW'(push) - CntW'(pop);

  assign out_r   = out_valid ? mem_r_q[rd_ptr_q]   : '0;
  assign out_tag = out_valid ? mem_tag_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_fmt    <= FP16;
      core_opcode <= OP_ADD;
      core_x      <= '0;
      core_y      <= '0;
    end else if (accept) begin
      core_fmt    <= in_fmt;
      core_opcode <= in_opcode;
      core_x      <= in_x;
      core_y      <= in_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < CORE_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      tag_q[0] <= in_tag;
      for (int i = 1; i < CORE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r_q[wr_ptr_q]   <= core_r;
      mem_tag_q[wr_ptr_q] <= tag_q[CORE_LAT-1];
    end
  end

  no_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CntW'(FIFO_DEPTH))));

`ifdef FPALL_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_bp     <= '0;
    end else begin
      if (accept && (perf_issued != '1))                  perf_issued <= perf_issued + 32'd1;
      if (in_valid && !in_ready && (perf_stall != '1))    perf_stall  <= perf_stall + 32'd1;
      if (out_valid && !out_ready && (perf_bp != '1))     perf_bp     <= perf_bp + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
// Bench for fpall_issue_ctrl: stands in for the FP unit with a bf16x2 adder and checks the DUT
// every cycle against a queue-based model of outstanding requests.
module tb_fpall_issue_ctrl;
  import FPALL_pkg::*;

  localparam int unsigned CoreLat   = 2;
  localparam int unsigned FifoDepth = 4;
  localparam int unsigned TagW      = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  fp_fmt_e         in_fmt = FP16;
  fp_op_e          in_opcode = OP_ADD;
  logic [31:0]     in_x = '0;
  logic [31:0]     in_y = '0;
  logic [TagW-1:0] in_tag = '0;
  fp_fmt_e         core_fmt;
  fp_op_e          core_opcode;
  logic [31:0]     core_x, core_y;
  logic [31:0]     core_r = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     out_r;
  logic [TagW-1:0] out_tag;
`ifdef FPALL_ISSUE_PERF_EN
  logic [31:0]     perf_issued, perf_stall, perf_bp;
`endif

  int checks = 0;
  int failures = 0;

  fpall_issue_ctrl #(.CORE_LAT(CoreLat), .FIFO_DEPTH(FifoDepth), .TAG_W(TagW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .core_fmt(core_fmt),
    .core_opcode(core_opcode), .core_x(core_x), .core_y(core_y), .core_r(core_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag)
`ifdef FPALL_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_bp(perf_bp)
`endif
  );

  always #5 clk = ~clk;

  function automatic real bf_to_real(input logic [15:0] b);
    real v;
    int  e;
    if (b[14:0] == 15'd0) return 0.0;
    v = 1.0 + real'(b[6:0]) / 128.0;
    e = int'(b[14:7]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_bf(input real v);
    logic s;
    real  a;
    int   e, m;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 128.0 + 0.5);
    return {s, e[7:0], m[6:0]};
  endfunction

  function automatic logic [31:0] add32(input logic [31:0] x, input logic [31:0] y);
    return {real_to_bf(bf_to_real(x[31:16]) + bf_to_real(y[31:16])),
            real_to_bf(bf_to_real(x[15:0]) + bf_to_real(y[15:0]))};
  endfunction

  // Quarter-step values in [-15.75, 15.75]: every sum is exact in bf16.
  function automatic logic [15:0] rbf();
    int k;
    k = int'($urandom_range(126, 0)) - 63;
    return real_to_bf(real'(k) / 4.0);
  endfunction

  // FP unit stand-in: result valid CoreLat cycles after the operand registers update.
  always @(posedge clk) core_r <= add32(core_x, core_y);

  typedef struct {
    logic [31:0]     r;
    logic [TagW-1:0] tag;
    int              avail;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  logic [31:0] m_x = '0, m_y = '0;
  fp_fmt_e     m_fmt = FP16;
  fp_op_e      m_op = OP_ADD;

  // Model: every accepted request is outstanding until popped; credits = FifoDepth - outstanding.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc = 0;
      m_x = '0; m_y = '0; m_fmt = FP16; m_op = OP_ADD;
    end else begin
      bit vis, acc;
      vis = (q.size() > 0) && (q[0].avail <= cyc);
      acc = in_valid && (q.size() < FifoDepth);
      cyc++;
      if (vis && out_ready) void'(q.pop_front());
      if (acc) begin
        q.push_back('{r: add32(in_x, in_y), tag: in_tag, avail: cyc + CoreLat});
        m_x = in_x; m_y = in_y; m_fmt = in_fmt; m_op = in_opcode;
        n_acc++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      bit vis;
      vis = (q.size() > 0) && (q[0].avail <= cyc);
      check("in_ready", 32'(in_ready), 32'(q.size() < FifoDepth));
      check("out_valid", 32'(out_valid), 32'(vis));
      check("out_r", out_r, vis ? q[0].r : 32'h0);
      check("out_tag", 32'(out_tag), vis ? 32'(q[0].tag) : 32'h0);
      check("core_x", core_x, m_x);
      check("core_y", core_y, m_y);
      check("core_fmt", 32'(core_fmt), 32'(m_fmt));
      check("core_opcode", 32'(core_opcode), 32'(m_op));
      if (out_valid && out_ready) n_pop++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_cnt, n0, p0, guard;

    // Reset values
    #3;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_core_x", core_x, 32'h0);
    check("rst_core_y", core_y, 32'h0);
    check("rst_core_fmt", 32'(core_fmt), 32'(FP16));
    check("rst_core_op", 32'(core_opcode), 32'(OP_ADD));
    check("rst_out_r", out_r, 32'h0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    tick();

    // Single op
    in_valid = 1'b1; in_x = 32'h3F803F80; in_y = 32'h3F803F80; in_tag = 4'd1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("single_core_x", core_x, 32'h3F803F80);
    check("single_v0", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("single_v1", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("single_v2", 32'(out_valid), 32'h1);
    check("single_r", out_r, 32'h40004000);
    check("single_tag", 32'(out_tag), 32'h1);
    @(negedge clk);
    check("single_v3", 32'(out_valid), 32'h0);
    tick();

    // Back-to-back three ops
    in_x = 32'h3FC03FC0; in_y = 32'hBFA0BFA0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_tag = TagW'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("b2b_valid", 32'(out_valid), 32'h1);
      check("b2b_r", out_r, 32'h3E803E80);
      check("b2b_tag", 32'(out_tag), 32'(i));
    end
    @(negedge clk);
    check("b2b_end", 32'(out_valid), 32'h0);
    tick();

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_x = 32'h3F803F80; in_y = 32'h3F803F80;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_tag = TagW'(i + 4);
      @(negedge clk);
      if (in_ready) acc_cnt++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepts", 32'(acc_cnt), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_hold_r", out_r, 32'h40004000);
      check("bp_hold_tag", 32'(out_tag), 32'd4);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_pre_ready", 32'(in_ready), 32'h0);
    check("drain_tag4", 32'(out_tag), 32'd4);
    @(negedge clk);
    check("drain_ready_back", 32'(in_ready), 32'h1);
    check("drain_tag5", 32'(out_tag), 32'd5);
    @(negedge clk);
    check("drain_tag6", 32'(out_tag), 32'd6);
    @(negedge clk);
    check("drain_tag7", 32'(out_tag), 32'd7);
    @(negedge clk);
    check("drain_empty", 32'(out_valid), 32'h0);
    tick();

    // Random traffic with random backpressure
    n0 = n_acc; p0 = n_pop; guard = 0;
    while ((n_acc - n0 < 100) && (guard < 3000)) begin
      in_valid  = ($urandom_range(9, 0) < 7);
      in_x      = {rbf(), rbf()};
      in_y      = {rbf(), rbf()};
      in_tag    = TagW'($urandom);
      out_ready = ($urandom_range(9, 0) < 7);
      tick();
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    check("rand_accepts", 32'(n_acc - n0), 32'd100);
    check("rand_pops", 32'(n_pop - p0), 32'd100);
    check("rand_model_empty", 32'(q.size()), 32'd0);

    // Async reset with 2 ops in FIFO and 2 in flight
    out_ready = 1'b0; in_x = 32'h3F803F80; in_y = 32'h3F803F80;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_tag = TagW'(8 + i);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_core_x", core_x, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'h0);
      check("post_rst_ready", 32'(in_ready), 32'h1);
    end
    tick();

`ifdef FPALL_ISSUE_PERF_EN
    // 4 accepts + 5 stalls, drain, then 6 more accepts
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (9) tick();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    in_valid = 1'b1;
    repeat (6) tick();
    in_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("perf_issued", perf_issued, 32'd10);
    check("perf_stall", perf_stall, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpall_issue_ctrl.md
Name: fpall_issue_ctrl

Overview:
Valid/ready issue and result-collection stage wrapped around the shared FP arithmetic unit FPALL_Shared_combine.
- Accepts operations (fmt, opcode, X, Y, tag) from an upstream requester and registers the operands driven into the unit.
- Tracks in-flight operations through the unit's fixed latency.
- Captures each result, with its tag, into an output FIFO drained by a downstream valid/ready consumer.
- Credit-based admission guarantees the FIFO never overflows, so the unit itself needs no stall.

Parameters:
- CORE_LAT, 2: cycles from operand-register update to valid core_r; must be ≥1.
- FIFO_DEPTH, 4: result FIFO entries; power of two, ≥2.
- TAG_W, 4: width of the opaque request tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at the clock edge.
- in_fmt  in  fp_fmt_e  format (FPALL_pkg); FP16 = bf16x2 packed lanes.
- in_opcode  in  fp_op_e  operation (FPALL_pkg), e.g. OP_ADD.
- in_x  in  32  operand X.
- in_y  in  32  operand Y.
- in_tag  in  TAG_W  tag returned with the result.
- core_fmt  out  fp_fmt_e  registered fmt driven to the unit.
- core_opcode  out  fp_op_e  registered opcode driven to the unit.
- core_x  out  32  registered X driven to the unit.
- core_y  out  32  registered Y driven to the unit.
- core_r  in  32  unit result.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer ready.
- out_r  out  32  result at FIFO head.
- out_tag  out  TAG_W  tag at FIFO head.

Behaviour:
Reset (async assert, sync release):
- core_x, core_y = 0; core_fmt = FP16; core_opcode = OP_ADD.
- Valid shift register cleared; FIFO pointers and count = 0.
- out_valid = 0; out_r, out_tag = 0; in_ready = 1 once reset releases.

Accept:
- At edge k with in_valid & in_ready, the core_* registers load the request.
- Otherwise core_* hold their previous values (no toggling on idle).

Tracking:
- A CORE_LAT-deep shift register of {valid, tag} advances every cycle.
- Stage 0 loads {accept, in_tag} at edge k.
- When the last stage is valid, core_r is written to the FIFO with its tag at edge k+CORE_LAT.
- out_valid is high from the cycle after that edge.
- Minimum in→out latency is CORE_LAT cycles. Throughput is 1 op/cycle.

Credits:
- inflight = count of valid bits in the shift register.
- in_ready = (inflight + fifo_count) < FIFO_DEPTH, computed from registered state only.
- in_ready has no combinational path from out_ready or in_valid.
- A pop at edge j frees a credit visible in the cycle after j.

FIFO:
- In-order; out_r/out_tag show the head entry.
- Pop when out_valid & out_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. This includes count = FIFO_DEPTH with a pop, and count = 0, where the pushed entry appears the next cycle with no bypass.
- Pointers wrap modulo FIFO_DEPTH.
- Push into a full FIFO without a pop is impossible by the credit rule; simulation asserts on it.

Output stability:
- While out_valid & !out_ready, out_r and out_tag hold.

Reset mid-operation:
- All in-flight ops and FIFO contents are discarded; no spurious out_valid after release.

Optional Feature:
FPALL_ISSUE_PERF_EN
- Defined: adds outputs perf_issued [31:0] (accepts), perf_stall [31:0] (cycles with in_valid & !in_ready) and perf_bp [31:0] (cycles with out_valid & !out_ready).
- Counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Single op: fmt = FP16, OP_ADD, X = 3F803F80, Y = 3F803F80, tag = 1 accepted at edge k, out_ready = 1 → out_valid in the cycle after edge k+2, out_r = 40004000, out_tag = 1, one cycle only.
- Back-to-back 3 ops: tags 1, 2, 3; X = 3FC03FC0, Y = BFA0BFA0 for all three → three consecutive out_valid cycles, out_r = 3E803E80, tags in order 1, 2, 3.
- Backpressure: out_ready = 0 with continuous in_valid → exactly 4 accepts, then in_ready = 0. out_r/out_tag stable. Raising out_ready drains 4 results in order, and in_ready re-asserts the cycle after the first pop.
- Full with simultaneous push/pop: count = 3, inflight = 1, out_ready = 1 → count stays ≤ 4, no assertion fires, no result lost or duplicated across 100 random ops checked against the bf16x2 add model.
- Async reset: assert rst_n = 0 mid-cycle with 2 ops in flight and 2 in the FIFO → out_valid drops immediately, core_x = 0. After release, no results appear and in_ready = 1.
- With FPALL_ISSUE_PERF_EN: 10 accepts and 5 stall cycles → perf_issued = 10, perf_stall = 5.
